// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - access-size encodings and byte-lane helpers for dmem_lsu
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  // Returned wide so callers cast down to their own lane count.
  function automatic logic [15:0] lane_strobe(input logic [1:0] size, input logic [2:0] lane,
                                              input int nb);
    logic [15:0] m;
    m = (16'd1 << size_bytes(size)) - 16'd1;
    m = (m << lane) & ((16'd1 << nb) - 16'd1);
    return m;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - byte-strobed single-port synchronous RAM with registered read data
module dmem_sram #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [DATA_W/8-1:0]            be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // No reset: contents must survive rst_n.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data memory with load/store lane unit, fault detection and sticky error capture
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [LB-1:0]     lane;
  logic [IDX_W-1:0]  index;
  logic              misalign;
  logic              out_of_range;
  logic              fault;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rdata_raw;
  logic              mem_we;

  logic              r_valid;
  logic              r_we;
  logic              r_fault;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [LB-1:0]     r_lane;

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;
  logic              sgn;
  int                nbits;

  assign lane         = req_addr[LB-1:0];
  assign index        = req_addr[LB+IDX_W-1:LB];
  assign out_of_range = |req_addr[ADDR_W-1:LB+IDX_W];

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      SIZE_H:  misalign = req_addr[0];
      SIZE_W:  misalign = |req_addr[1:0];
      SIZE_D:  misalign = (DATA_W == 32) ? 1'b1 : |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign fault    = misalign | out_of_range;
  assign be       = NB'(lane_strobe(req_size, 3'(lane), NB));
  assign wdata_sh = req_wdata << {lane, 3'b000};
  // Gated by rst_n so a request held during reset cannot disturb memory.
  assign mem_we   = rst_n & req_valid & req_we & ~fault;

  dmem_sram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .be    (be),
    .addr  (index),
    .wdata (wdata_sh),
    .rdata (rdata_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
      r_size  <= SIZE_B;
      r_uns   <= 1'b0;
      r_lane  <= '0;
    end else begin
      r_valid <= req_valid;
      r_we    <= req_valid & req_we;
      r_fault <= req_valid & fault;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_lane  <= lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (req_valid && fault) begin
      // A clear coinciding with a new fault re-arms capture on that fault.
      if (!err_flag || err_clr) begin
        err_flag <= 1'b1;
        err_addr <= req_addr;
      end
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end

  always_comb begin
    sh    = rdata_raw >> {r_lane, 3'b000};
    nbits = size_bytes(r_size) * 8;
    case (r_size)
      SIZE_B:  sgn = sh[7];
      SIZE_H:  sgn = sh[15];
      SIZE_W:  sgn = sh[31];
      default: sgn = sh[DATA_W-1];
    endcase
    sgn = sgn & ~r_uns;
    ext = '0;
    for (int i = 0; i < DATA_W; i++) ext[i] = (i < nbits) ? sh[i] : sgn;
  end

  assign rsp_valid = r_valid;
  assign rsp_fault = r_fault;
  assign rsp_rdata = (r_valid && !r_we && !r_fault) ? ext : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - table-driven scoreboard bench for dmem_lsu (32-bit and 64-bit builds)
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, err_clr = 1'b0;
  logic [1:0]  req_size = SIZE_B;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_fault, err_flag;
  logic [31:0] rsp_rdata, err_addr;

  logic        d_rst_n = 1'b0;
  logic        d_valid = 1'b0, d_we = 1'b0, d_uns = 1'b0;
  logic [1:0]  d_size = SIZE_B;
  logic [31:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_rsp_valid, d_rsp_fault, d_err_flag;
  logic [63:0] d_rsp_rdata;
  logic [31:0] d_err_addr;

  always #5 clk = ~clk;

  dmem_lsu #(.DATA_W(32), .DEPTH_WORDS(1024), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
  );

  dmem_lsu #(.DATA_W(64), .DEPTH_WORDS(1024), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(d_rst_n), .req_valid(d_valid), .req_we(d_we), .req_size(d_size),
    .req_unsigned(d_uns), .req_addr(d_addr), .req_wdata(d_wdata),
    .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata), .rsp_fault(d_rsp_fault),
    .err_flag(d_err_flag), .err_addr(d_err_addr), .err_clr(1'b0)
  );

  // ctl = {rst, valid, we, unsigned, clr}; ex = {rsp_valid, rsp_fault, err_flag}
  typedef struct {
    logic [4:0]  ctl;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  ex;
    logic [31:0] er;
    logic [31:0] ea;
  } vec_t;

  typedef struct {
    int          row;
    logic [2:0]  ex;
    logic [31:0] er;
    logic [31:0] ea;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_head();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("row%0d rsp_valid", e.row), 64'(rsp_valid), 64'(e.ex[2]));
      chk($sformatf("row%0d rsp_fault", e.row), 64'(rsp_fault), 64'(e.ex[1]));
      chk($sformatf("row%0d rsp_rdata", e.row), 64'(rsp_rdata), 64'(e.er));
      chk($sformatf("row%0d err_flag", e.row), 64'(err_flag), 64'(e.ex[0]));
      chk($sformatf("row%0d err_addr", e.row), 64'(err_addr), 64'(e.ea));
    end
  endtask

  task automatic d_drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wd);
    d_valid = v; d_we = we; d_size = sz; d_uns = uns; d_addr = addr; d_wdata = wd;
  endtask

  task automatic d_chk(input string nm, input logic v, input logic [63:0] rd, input logic f);
    chk({nm, " valid"}, 64'(d_rsp_valid), 64'(v));
    chk({nm, " rdata"}, d_rsp_rdata, rd);
    chk({nm, " fault"}, 64'(d_rsp_fault), 64'(f));
  endtask

  initial begin
    tbl.push_back('{5'b01100, SIZE_W, 32'h10,   32'hDEADBEEF, 3'b100, 32'h0,        32'h0});
    tbl.push_back('{5'b01000, SIZE_W, 32'h10,   32'h0,        3'b100, 32'hDEADBEEF, 32'h0});
    tbl.push_back('{5'b01100, SIZE_B, 32'h13,   32'h000000A5, 3'b100, 32'h0,        32'h0});
    tbl.push_back('{5'b01000, SIZE_B, 32'h13,   32'h0,        3'b100, 32'hFFFFFFA5, 32'h0});
    tbl.push_back('{5'b01010, SIZE_B, 32'h13,   32'h0,        3'b100, 32'h000000A5, 32'h0});
    tbl.push_back('{5'b01000, SIZE_W, 32'h10,   32'h0,        3'b100, 32'hA5ADBEEF, 32'h0});
    tbl.push_back('{5'b01100, SIZE_H, 32'h12,   32'h00008001, 3'b100, 32'h0,        32'h0});
    tbl.push_back('{5'b01000, SIZE_H, 32'h12,   32'h0,        3'b100, 32'hFFFF8001, 32'h0});
    tbl.push_back('{5'b01000, SIZE_H, 32'h11,   32'h0,        3'b111, 32'h0,        32'h11});
    tbl.push_back('{5'b01100, SIZE_W, 32'h12,   32'h12345678, 3'b111, 32'h0,        32'h11});
    tbl.push_back('{5'b01000, SIZE_W, 32'h10,   32'h0,        3'b101, 32'h8001BEEF, 32'h11});
    tbl.push_back('{5'b01000, SIZE_W, 32'h1000, 32'h0,        3'b111, 32'h0,        32'h11});
    tbl.push_back('{5'b00000, SIZE_B, 32'h0,    32'h0,        3'b001, 32'h0,        32'h11});
    tbl.push_back('{5'b01001, SIZE_W, 32'h21,   32'h0,        3'b111, 32'h0,        32'h21});
    tbl.push_back('{5'b00001, SIZE_B, 32'h0,    32'h0,        3'b000, 32'h0,        32'h21});
    tbl.push_back('{5'b01000, SIZE_D, 32'h18,   32'h0,        3'b111, 32'h0,        32'h18});
    tbl.push_back('{5'b01010, SIZE_H, 32'h12,   32'h0,        3'b101, 32'h00008001, 32'h18});
    tbl.push_back('{5'b01000, SIZE_B, 32'h11,   32'h0,        3'b101, 32'hFFFFFFBE, 32'h18});
    tbl.push_back('{5'b01100, SIZE_W, 32'h14,   32'h0,        3'b101, 32'h0,        32'h18});
    tbl.push_back('{5'b01100, SIZE_B, 32'h15,   32'h12345677, 3'b101, 32'h0,        32'h18});
    tbl.push_back('{5'b01000, SIZE_W, 32'h14,   32'h0,        3'b101, 32'h00007700, 32'h18});
    tbl.push_back('{5'b11000, SIZE_W, 32'h10,   32'h0,        3'b000, 32'h0,        32'h0});
    tbl.push_back('{5'b01000, SIZE_W, 32'h10,   32'h0,        3'b100, 32'h8001BEEF, 32'h0});

    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset rsp_fault", 64'(rsp_fault), 64'd0);
    chk("reset err_flag", 64'(err_flag), 64'd0);
    chk("reset err_addr", 64'(err_addr), 64'd0);
    rst_n = 1'b1;
    d_rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      check_head();
      rst_n        = ~tbl[k].ctl[4];
      req_valid    = tbl[k].ctl[3];
      req_we       = tbl[k].ctl[2];
      req_unsigned = tbl[k].ctl[1];
      err_clr      = tbl[k].ctl[0];
      req_size     = tbl[k].sz;
      req_addr     = tbl[k].addr;
      req_wdata    = tbl[k].wd;
      sb.push_back('{k, tbl[k].ex, tbl[k].er, tbl[k].ea});
    end
    @(negedge clk);
    check_head();
    req_valid = 1'b0;
    err_clr   = 1'b0;
    @(negedge clk);
    chk("idle rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle rsp_rdata", 64'(rsp_rdata), 64'd0);

    d_drive(1'b1, 1'b1, SIZE_D, 1'b0, 32'h8, 64'h0123456789ABCDEF);
    @(negedge clk);
    d_chk("d64 store", 1'b1, 64'h0, 1'b0);
    d_drive(1'b1, 1'b0, SIZE_D, 1'b0, 32'h8, 64'h0);
    @(negedge clk);
    d_chk("d64 load dword", 1'b1, 64'h0123456789ABCDEF, 1'b0);
    d_drive(1'b1, 1'b0, SIZE_W, 1'b0, 32'h8, 64'h0);
    @(negedge clk);
    d_chk("d64 load word signed", 1'b1, 64'hFFFFFFFF89ABCDEF, 1'b0);
    d_drive(1'b1, 1'b0, SIZE_W, 1'b1, 32'hC, 64'h0);
    @(negedge clk);
    d_chk("d64 load word hi", 1'b1, 64'h0000000001234567, 1'b0);
    d_drive(1'b1, 1'b0, SIZE_D, 1'b0, 32'h4, 64'h0);
    @(negedge clk);
    d_chk("d64 misaligned dword", 1'b1, 64'h0, 1'b1);
    chk("d64 err_flag", 64'(d_err_flag), 64'd1);
    chk("d64 err_addr", 64'(d_err_addr), 64'h4);
    d_drive(1'b0, 1'b0, SIZE_B, 1'b0, 32'h0, 64'h0);
    @(negedge clk);
    d_chk("d64 idle", 1'b0, 64'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
